// File: rtl/alu_shift_seq.sv
// Iterative multi-mode shifter with a start/busy/done handshake and registered result/carry-out.
// Define ALU_SHIFT_BARREL_EN to replace the one-bit-per-cycle datapath with a single-cycle barrel shifter.
module alu_shift_seq #(
   parameter int ancho = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ancho-1:0] a,
   input  logic [ancho-1:0] b,
   input  logic [1:0]       mode,
   input  logic             aluflagin,
   output logic             busy,
   output logic             done,
   output logic [ancho-1:0] aluresult,
   output logic             aluflags
);

   localparam int cntw = $clog2(ancho + 1);
   localparam logic [ancho-1:0] anchov   = ancho'(ancho);
   localparam logic [cntw-1:0]  fullcnt  = cntw'(ancho);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, nextstate;
   logic            accept;
   logic [cntw-1:0] beff;

   // One-bit step shared by both builds; the top bit of the return value is the bit shifted out.
   function automatic logic [ancho:0] step(input logic [ancho-1:0] v, input logic [1:0] m);
      logic [ancho:0] r;
      case (m)
         2'b00:   r = {v[0], 1'b0, v[ancho-1:1]};
         2'b01:   r = {v[0], v[ancho-1], v[ancho-1:1]};
         2'b10:   r = {v[ancho-1], v[ancho-2:0], 1'b0};
         default: r = {v[0], v[0], v[ancho-1:1]};
      endcase
      return r;
   endfunction

   assign accept = start && (state != SHIFT);
   assign beff   = (b >= anchov) ? fullcnt : cntw'(b);

`ifdef ALU_SHIFT_BARREL_EN
   logic [ancho-1:0] bres;
   logic             bcar;

   // Unrolled chain of single steps, so results match the iterative build bit for bit.
   always_comb begin
      bres = a;
      bcar = 1'b0;
      for (int i = 0; i < ancho; i++) begin
         if (cntw'(i) < beff) begin
            {bcar, bres} = step(bres, mode);
         end
      end
   end
`else
   logic [ancho-1:0] work;
   logic [cntw-1:0]  cnt;
   logic [1:0]       md;
   logic             flg;
   logic [ancho:0]   stepped;

   assign stepped = step(work, md);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextstate;
      end
   end

   always_comb begin
      nextstate = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
`ifdef ALU_SHIFT_BARREL_EN
               nextstate = DONE;
`else
               nextstate = (beff == '0) ? DONE : SHIFT;
`endif
            end else begin
               nextstate = IDLE;
            end
         end
         SHIFT: begin
`ifdef ALU_SHIFT_BARREL_EN
            nextstate = IDLE;
`else
            if (cnt == cntw'(1)) begin
               nextstate = DONE;
            end
`endif
         end
         default: nextstate = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
      done = (state == DONE);
   end

   // Result registers only load on the edge that enters DONE, so they hold between operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aluresult <= '0;
         aluflags  <= 1'b0;
`ifndef ALU_SHIFT_BARREL_EN
         work      <= '0;
         cnt       <= '0;
         md        <= 2'b00;
         flg       <= 1'b0;
`endif
      end else begin
`ifdef ALU_SHIFT_BARREL_EN
         if (accept) begin
            aluresult <= {bres[ancho-1:1], bres[0] | aluflagin};
            aluflags  <= bcar;
         end
`else
         if (accept) begin
            work <= a;
            cnt  <= beff;
            md   <= mode;
            flg  <= aluflagin;
            if (beff == '0) begin
               aluresult <= {a[ancho-1:1], a[0] | aluflagin};
               aluflags  <= 1'b0;
            end
         end else if (state == SHIFT) begin
            work <= stepped[ancho-1:0];
            cnt  <= cnt - cntw'(1);
            if (cnt == cntw'(1)) begin
               aluresult <= {stepped[ancho-1:1], stepped[0] | flg};
               aluflags  <= stepped[ancho];
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq at ancho=4: directed vectors, handshake corners and mid-operation reset.
// Expectations follow the iterative build unless ALU_SHIFT_BARREL_EN is defined.
module tb_alu_shift_seq;

   localparam int ancho = 4;

   typedef struct {
      logic [3:0] res;
      logic       flg;
      int         donecyc;
      int         busycyc;
   } exp_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] m;
      logic       f;
      logic [3:0] res;
      logic       flg;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic [1:0] mode;
   logic       aluflagin;
   logic       busy;
   logic       done;
   logic [3:0] aluresult;
   logic       aluflags;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   expdone = 0;
   int   donecnt = 0;
   int   busycnt = 0;
   logic [3:0] prevres = '0;
   logic       prevflg = 1'b0;
   exp_t sbq[$];
   vec_t vecs[$];

   alu_shift_seq #(.ancho(ancho)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .a(a),
      .b(b),
      .mode(mode),
      .aluflagin(aluflagin),
      .busy(busy),
      .done(done),
      .aluresult(aluresult),
      .aluflags(aluflags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic int effcount(input logic [3:0] bb);
      return (bb >= 4'd4) ? 4 : int'(bb);
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue the expectation for an operation whose start is seen by the next rising edge.
   task automatic pushExpect(input logic [3:0] bb, input logic [3:0] eres, input logic eflg);
      exp_t e;
      e.res = eres;
      e.flg = eflg;
`ifdef ALU_SHIFT_BARREL_EN
      e.donecyc = cyc + 1;
      e.busycyc = 0;
`else
      e.donecyc = cyc + 1 + effcount(bb);
      e.busycyc = effcount(bb);
`endif
      sbq.push_back(e);
      expdone++;
   endtask

   // Called just after a falling edge; leaves start low one cycle later.
   task automatic applyStimulus(input vec_t v);
      start     = 1'b1;
      a         = v.a;
      b         = v.b;
      mode      = v.m;
      aluflagin = v.f;
      pushExpect(v.b, v.res, v.flg);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone();
      int k;
      k = 0;
      while ((sbq.size() != 0 || busy || done) && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (k >= 40) begin
         checks++;
         failures++;
         $display("[TB] FAIL timeout: %0d results still pending, expected 0", sbq.size());
      end
      @(negedge clk);
   endtask

   // Monitor: pops one expectation per done pulse; outside done the outputs must not move.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busycnt = 0;
      end else begin
         if (busy) busycnt++;
         if (done) begin
            donecnt++;
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_done: got done with result %0h, expected no done", aluresult);
            end else begin
               e = sbq.pop_front();
               checkOutput("aluresult", int'(aluresult), int'(e.res));
               checkOutput("aluflags", int'(aluflags), int'(e.flg));
               checkOutput("done_cycle", cyc, e.donecyc);
               checkOutput("busy_cycles", busycnt, e.busycyc);
            end
            busycnt = 0;
         end else begin
            checkOutput("hold_outputs", int'({aluflags, aluresult}), int'({prevflg, prevres}));
         end
      end
      prevres = aluresult;
      prevflg = aluflags;
   end

   initial begin
      vec_t v;
      rst       = 1'b1;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      mode      = 2'b00;
      aluflagin = 1'b0;

      vecs.push_back('{4'b1011, 4'd2,  2'b00, 1'b0, 4'b0010, 1'b1});
      vecs.push_back('{4'b1000, 4'd1,  2'b01, 1'b1, 4'b1101, 1'b0});
      vecs.push_back('{4'b1001, 4'd1,  2'b10, 1'b0, 4'b0010, 1'b1});
      vecs.push_back('{4'b0110, 4'd0,  2'b00, 1'b1, 4'b0111, 1'b0});
      vecs.push_back('{4'b1010, 4'd9,  2'b11, 1'b0, 4'b1010, 1'b1});
      vecs.push_back('{4'b1011, 4'd15, 2'b01, 1'b0, 4'b1111, 1'b1});
      vecs.push_back('{4'b0111, 4'd4,  2'b10, 1'b1, 4'b0001, 1'b1});
      vecs.push_back('{4'b1101, 4'd3,  2'b11, 1'b0, 4'b1011, 1'b1});
      vecs.push_back('{4'b1011, 4'd4,  2'b00, 1'b0, 4'b0000, 1'b1});
      vecs.push_back('{4'b1001, 4'd2,  2'b01, 1'b0, 4'b1110, 1'b0});

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_aluresult", int'(aluresult), 0);
      checkOutput("reset_aluflags", int'(aluflags), 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         waitDone();
      end

      // A start arriving while the shift is in progress must be dropped.
      v = '{4'b0001, 4'd3, 2'b00, 1'b0, 4'b0000, 1'b0};
      applyStimulus(v);
      start = 1'b1;
      a     = 4'b1111;
      b     = 4'd0;
`ifdef ALU_SHIFT_BARREL_EN
      pushExpect(4'd0, 4'b1111, 1'b0);
`endif
      @(negedge clk);
      start = 1'b0;
      waitDone();

      // Start held high through DONE launches the next operation with no idle cycle.
      start     = 1'b1;
      a         = 4'b1000;
      b         = 4'd1;
      mode      = 2'b00;
      aluflagin = 1'b0;
      pushExpect(4'd1, 4'b0100, 1'b0);
      @(negedge clk);
`ifndef ALU_SHIFT_BARREL_EN
      a         = 4'b0011;
      b         = 4'd0;
      aluflagin = 1'b1;
      @(negedge clk);
`else
      a         = 4'b0011;
      b         = 4'd0;
      aluflagin = 1'b1;
`endif
      pushExpect(4'd0, 4'b0011, 1'b0);
      @(negedge clk);
      start = 1'b0;
      waitDone();

      // Reset in the middle of a shift abandons it without a done pulse.
      v = '{4'b1110, 4'd3, 2'b00, 1'b0, 4'b0001, 1'b1};
      applyStimulus(v);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_done", int'(done), 0);
      checkOutput("midrst_aluresult", int'(aluresult), 0);
      checkOutput("midrst_aluflags", int'(aluflags), 0);
      expdone = expdone - sbq.size();
      sbq.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      applyStimulus(vecs[7]);
      waitDone();
      applyStimulus(vecs[0]);
      waitDone();

      checkOutput("done_count", donecnt, expdone);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
